// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings plus the combinational helpers used by the datapath
// (immediate extension and ALU).
package riscv_pkg;

  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_ctl_e;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;

  localparam logic [31:0] NOP = 32'h00000013;

  // Decode-stage control bundle; an all-zero value is a bubble.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_t;

  function automatic logic [31:0] extend(input logic [31:7] i, input logic [1:0] src);
    case (src)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      default: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] ctl);
    case (ctl)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_datapath_hazard.sv
// Hazard unit: EX operand forward selects, load-use stall, and branch/jump flushes.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       load_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       pc_src_e,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e
);

  logic lw_stall;

  // The younger producer (MEM) wins over WB; x0 is never forwarded.
  function automatic logic [1:0] pick(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                      input logic ww, input logic [4:0] rdw);
    if (rs == 5'd0)          return FWD_REG;
    if (wm && rdm == rs)     return FWD_MEM;
    if (ww && rdw == rs)     return FWD_WB;
    return FWD_REG;
  endfunction

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (HAZARD_EN) begin
      fwd_a = pick(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
      fwd_b = pick(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
    end
  end

  assign lw_stall = HAZARD_EN && load_e && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d);
  assign stall_f  = lw_stall;
  assign stall_d  = lw_stall;
  assign flush_d  = pc_src_e;
  assign flush_e  = lw_stall | pc_src_e;

endmodule

// File: rtl/pipelined_datapath.sv
// Five-stage RV32I datapath (IF/ID/EX/MEM/WB) with forwarding, load-use stall and
// branch/jump flush; the external controller decodes InstrD.
module pipelined_datapath
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter bit              HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] PCF,
  input  logic [31:0]     InstrF,
  output logic [31:0]     InstrD,
  input  logic            RegWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ImmSrcD,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] ReadDataM
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
  } ex_mem_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
  } mem_wb_t;

  if_id_t  d;
  id_ex_t  e;
  ex_mem_t m;
  mem_wb_t w;

  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] pc_plus4_f, rd1_d, rd2_d;
  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e, pc_target_e, result_w;
  logic [4:0]      rs1_d, rs2_d;
  logic [1:0]      fwd_a, fwd_b;
  logic            zero_e, pc_src_e, stall_f, stall_d, flush_d, flush_e;
  ctrl_t           ctrl_d;

  // ---------------- IF ----------------
  assign pc_plus4_f = PCF + XLEN'(4);

  always_ff @(posedge clk or posedge reset)
    if (reset)          PCF <= RESET_PC;
    else if (pc_src_e)  PCF <= pc_target_e;
    else if (!stall_f)  PCF <= pc_plus4_f;

  always_ff @(posedge clk or posedge reset)
    if (reset)         d <= '0;
    else if (flush_d)  d <= '0;
    else if (!stall_d) d <= '{instr: InstrF, pc: PCF, pc_plus4: pc_plus4_f};

  // ---------------- ID ----------------
  assign InstrD = d.instr;
  assign rs1_d  = d.instr[19:15];
  assign rs2_d  = d.instr[24:20];
  assign ctrl_d = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD};

  // Write-through so a WB write is visible to the instruction reading in the same cycle.
  always_comb begin
    rd1_d = rf[rs1_d];
    rd2_d = rf[rs2_d];
    if (w.reg_write && w.rd != 5'd0 && w.rd == rs1_d) rd1_d = result_w;
    if (w.reg_write && w.rd != 5'd0 && w.rd == rs2_d) rd2_d = result_w;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)                           for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (w.reg_write && w.rd != 5'd0) rf[w.rd] <= result_w;

  always_ff @(posedge clk or posedge reset)
    if (reset)        e <= '0;
    else if (flush_e) e <= '0;
    else              e <= '{ctrl: ctrl_d, rd1: rd1_d, rd2: rd2_d, pc: d.pc, pc_plus4: d.pc_plus4,
                             imm: extend(d.instr[31:7], ImmSrcD), rs1: rs1_d, rs2: rs2_d,
                             rd: d.instr[11:7]};

  // ---------------- EX ----------------
  always_comb begin
    case (fwd_a)
      FWD_MEM: src_a_e = m.alu_result;
      FWD_WB:  src_a_e = result_w;
      default: src_a_e = e.rd1;
    endcase
    case (fwd_b)
      FWD_MEM: write_data_e = m.alu_result;
      FWD_WB:  write_data_e = result_w;
      default: write_data_e = e.rd2;
    endcase
  end

  assign src_b_e      = e.ctrl.alu_src ? e.imm : write_data_e;
  assign alu_result_e = alu(src_a_e, src_b_e, e.ctrl.alu_control);
  assign zero_e       = (alu_result_e == '0);
  assign pc_target_e  = e.pc + e.imm;
  assign pc_src_e     = (e.ctrl.branch & zero_e) | e.ctrl.jump;

  always_ff @(posedge clk or posedge reset)
    if (reset) m <= '0;
    else       m <= '{reg_write: e.ctrl.reg_write, result_src: e.ctrl.result_src,
                      mem_write: e.ctrl.mem_write, alu_result: alu_result_e,
                      write_data: write_data_e, pc_plus4: e.pc_plus4, rd: e.rd};

  // ---------------- MEM ----------------
  assign MemWriteM  = m.mem_write;
  assign ALUResultM = m.alu_result;
  assign WriteDataM = m.write_data;

  always_ff @(posedge clk or posedge reset)
    if (reset) w <= '0;
    else       w <= '{reg_write: m.reg_write, result_src: m.result_src, alu_result: m.alu_result,
                      read_data: ReadDataM, pc_plus4: m.pc_plus4, rd: m.rd};

  // ---------------- WB ----------------
  always_comb begin
    case (w.result_src)
      RES_MEM: result_w = w.read_data;
      RES_PC4: result_w = w.pc_plus4;
      default: result_w = w.alu_result;
    endcase
  end

  hazard_unit #(.HAZARD_EN(HAZARD_EN)) u_hazard (
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (e.rs1),
    .rs2_e       (e.rs2),
    .rd_e        (e.rd),
    .rd_m        (m.rd),
    .rd_w        (w.rd),
    .load_e      (e.ctrl.result_src == RES_MEM),
    .reg_write_m (m.reg_write),
    .reg_write_w (w.reg_write),
    .pc_src_e    (pc_src_e),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e)
  );

endmodule

// File: tb/tb_pipelined_datapath.sv
// Bench for pipelined_datapath: acts as controller, imem and dmem; directed hazard
// scenarios plus random programs checked against an instruction-level reference model.
module tb_pipelined_datapath;

  localparam int OP_ADDI = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4, OP_SLT = 5,
                 OP_LW = 6, OP_SW = 7, OP_BEQ = 8, OP_JAL = 9, OP_HALT = 10;

  typedef struct { int op; int rd; int rs1; int rs2; int imm; } ins_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCF, InstrF, InstrD, ALUResultM, WriteDataM, ReadDataM;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MemWriteM;
  logic [1:0]  ResultSrcD, ImmSrcD;
  logic [2:0]  ALUControlD;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] dmem_init [64];
  ins_t        prog [$];
  logic [63:0] got_st [$];
  logic [63:0] exp_st [$];
  logic [31:0] pc_trace [$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  pipelined_datapath dut (
    .clk(clk), .reset(reset), .PCF(PCF), .InstrF(InstrF), .InstrD(InstrD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .ImmSrcD(ImmSrcD),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM)
  );

  assign InstrF    = imem[PCF[7:2]];
  assign ReadDataM = dmem[ALUResultM[7:2]];

  // External controller: opcode decode of the decode-stage instruction.
  always_comb begin
    RegWriteD = 1'b0; ResultSrcD = 2'b00; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0;
    ALUControlD = 3'b000; ALUSrcD = 1'b0; ImmSrcD = 2'b00;
    case (InstrD[6:0])
      7'h03: begin RegWriteD = 1'b1; ResultSrcD = 2'b01; ALUSrcD = 1'b1; end
      7'h23: begin MemWriteD = 1'b1; ALUSrcD = 1'b1; ImmSrcD = 2'b01; end
      7'h33, 7'h13: begin
        RegWriteD = 1'b1;
        ALUSrcD   = (InstrD[6:0] == 7'h13);
        case (InstrD[14:12])
          3'b000:  ALUControlD = (InstrD[6:0] == 7'h33 && InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  ALUControlD = 3'b101;
          3'b110:  ALUControlD = 3'b011;
          3'b111:  ALUControlD = 3'b010;
          default: ALUControlD = 3'b000;
        endcase
      end
      7'h63: begin BranchD = 1'b1; ALUControlD = 3'b001; ImmSrcD = 2'b10; end
      7'h6f: begin JumpD = 1'b1; RegWriteD = 1'b1; ResultSrcD = 2'b10; ImmSrcD = 2'b11; end
      default: ;
    endcase
  end

  // Data memory and store log; both restart while reset is held.
  always @(posedge clk) begin
    if (reset) begin
      got_st.delete();
      foreach (dmem[k]) dmem[k] <= dmem_init[k];
    end else if (MemWriteM) begin
      dmem[ALUResultM[7:2]] <= WriteDataM;
      got_st.push_back({ALUResultM, WriteDataM});
    end
  end

  task automatic new_prog();
    prog.delete();
    foreach (imem[k]) imem[k] = 32'h00000013;
    foreach (dmem_init[k]) dmem_init[k] = '0;
  endtask

  task automatic emit(input int op, input int rd, input int rs1, input int rs2, input int imm);
    ins_t t; logic [31:0] wd; logic [20:0] i; logic [4:0] a, b, r;
    i = 21'(imm); a = 5'(rs1); b = 5'(rs2); r = 5'(rd);
    t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    case (op)
      OP_ADDI: wd = {i[11:0], a, 3'b000, r, 7'h13};
      OP_ADD:  wd = {7'h00, b, a, 3'b000, r, 7'h33};
      OP_SUB:  wd = {7'h20, b, a, 3'b000, r, 7'h33};
      OP_AND:  wd = {7'h00, b, a, 3'b111, r, 7'h33};
      OP_OR:   wd = {7'h00, b, a, 3'b110, r, 7'h33};
      OP_SLT:  wd = {7'h00, b, a, 3'b010, r, 7'h33};
      OP_LW:   wd = {i[11:0], a, 3'b010, r, 7'h03};
      OP_SW:   wd = {i[11:5], b, a, 3'b010, i[4:0], 7'h23};
      OP_BEQ:  wd = {i[12], i[10:5], b, a, 3'b000, i[4:1], i[11], 7'h63};
      OP_JAL:  wd = {i[20], i[10:1], i[11], i[19:12], r, 7'h6f};
      default: wd = 32'h0000006f;
    endcase
    imem[prog.size()] = wd;
    prog.push_back(t);
  endtask

  // Instruction-at-a-time architectural model producing the expected store sequence.
  task automatic ref_run();
    logic [31:0] r [32]; logic [31:0] mm [64]; logic [31:0] a, v; int pc, nxt; bit wr; ins_t t;
    foreach (r[k]) r[k] = '0;
    foreach (mm[k]) mm[k] = dmem_init[k];
    exp_st.delete();
    pc = 0;
    for (int n = 0; n < 400; n++) begin
      if (pc / 4 >= prog.size()) break;
      t = prog[pc / 4];
      if (t.op == OP_HALT) break;
      nxt = pc + 4; wr = 1'b1; v = '0;
      case (t.op)
        OP_ADDI: v = r[t.rs1] + 32'(t.imm);
        OP_ADD:  v = r[t.rs1] + r[t.rs2];
        OP_SUB:  v = r[t.rs1] - r[t.rs2];
        OP_AND:  v = r[t.rs1] & r[t.rs2];
        OP_OR:   v = r[t.rs1] | r[t.rs2];
        OP_SLT:  v = ($signed(r[t.rs1]) < $signed(r[t.rs2])) ? 32'd1 : 32'd0;
        OP_LW:   begin a = r[t.rs1] + 32'(t.imm); v = mm[a[7:2]]; end
        OP_SW:   begin
          wr = 1'b0; a = r[t.rs1] + 32'(t.imm);
          mm[a[7:2]] = r[t.rs2];
          exp_st.push_back({a, r[t.rs2]});
        end
        OP_BEQ:  begin wr = 1'b0; if (r[t.rs1] == r[t.rs2]) nxt = pc + t.imm; end
        default: begin v = 32'(pc + 4); nxt = pc + t.imm; end
      endcase
      if (wr && t.rd != 0) r[t.rd] = v;
      pc = nxt;
    end
  endtask

  task automatic run_dut(input int cycles);
    reset = 1'b1;
    pc_trace.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pc_trace.push_back(PCF);
    repeat (cycles) begin
      @(negedge clk);
      pc_trace.push_back(PCF);
    end
  endtask

  task automatic test_reset();
    new_prog();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (PCF !== 32'h0 || InstrD !== 32'h0 || MemWriteM !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got pcf=%h instrd=%h memwrite=%b exp 0/0/0", PCF, InstrD, MemWriteM);
    end
    emit(OP_ADDI, 1, 0, 0, 5);
    for (int k = 0; k < 6; k++) emit(OP_SW, 0, 0, 1, 'h60 + 4 * k);
    emit(OP_HALT, 0, 0, 0, 0);
    run_dut(5);
    reset = 1'b1;
    #1;
    vectors++;
    if (PCF !== 32'h0 || InstrD !== 32'h0 || MemWriteM !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midrun: got pcf=%h instrd=%h memwrite=%b exp 0/0/0", PCF, InstrD, MemWriteM);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (PCF !== 32'h0 || MemWriteM !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: got pcf=%h memwrite=%b exp 0/0", PCF, MemWriteM);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (MemWriteM !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_side_effect c%0d: got memwrite=%b exp 0", c, MemWriteM);
      end
      @(negedge clk);
    end
    vectors++;
    if (MemWriteM !== 1'b1 || ALUResultM !== 32'h60 || WriteDataM !== 32'd5) begin
      miscompares++;
      $display("FAIL reset_restart: got memwrite=%b addr=%h data=%h exp 1/60/5",
               MemWriteM, ALUResultM, WriteDataM);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
    logic [63:0] want [$] = '{{32'h40, 32'd10}, {32'h44, 32'd15}};
    new_prog();
    emit(OP_ADDI, 1, 0, 0, 5);
    emit(OP_ADD, 2, 1, 1, 0);
    emit(OP_ADD, 3, 2, 1, 0);
    emit(OP_SW, 0, 0, 2, 'h40);
    emit(OP_SW, 0, 0, 3, 'h44);
    emit(OP_HALT, 0, 0, 0, 0);
    run_dut(16);
    foreach (exp_pc[i]) begin
      vectors++;
      if (pc_trace[i] !== exp_pc[i]) begin
        miscompares++;
        $display("FAIL back_to_back_pcf c%0d: got %h exp %h", i, pc_trace[i], exp_pc[i]);
      end
    end
    foreach (want[i]) begin
      vectors++;
      if (i >= got_st.size() || got_st[i] !== want[i]) begin
        miscompares++;
        $display("FAIL back_to_back_store %0d: got %h exp %h", i,
                 (i < got_st.size()) ? got_st[i] : 64'hx, want[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] exp_pc [6] = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12, 32'd16};
    new_prog();
    dmem_init[0] = 32'd7;
    emit(OP_LW, 4, 0, 0, 0);
    emit(OP_ADD, 5, 4, 4, 0);
    emit(OP_SW, 0, 0, 5, 'h48);
    emit(OP_HALT, 0, 0, 0, 0);
    run_dut(14);
    foreach (exp_pc[i]) begin
      vectors++;
      if (pc_trace[i] !== exp_pc[i]) begin
        miscompares++;
        $display("FAIL load_use_pcf c%0d: got %h exp %h", i, pc_trace[i], exp_pc[i]);
      end
    end
    vectors++;
    if (got_st.size() != 1 || got_st[0] !== {32'h48, 32'd14}) begin
      miscompares++;
      $display("FAIL load_use_store: got n=%0d first=%h exp n=1 %h", got_st.size(),
               (got_st.size() > 0) ? got_st[0] : 64'hx, {32'h48, 32'd14});
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [6] = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12, 32'd16};
    new_prog();
    emit(OP_BEQ, 0, 0, 0, 8);
    emit(OP_SW, 0, 0, 0, 'h50);
    emit(OP_ADDI, 7, 0, 0, 3);
    emit(OP_SW, 0, 0, 7, 'h54);
    emit(OP_HALT, 0, 0, 0, 0);
    run_dut(16);
    foreach (exp_pc[i]) begin
      vectors++;
      if (pc_trace[i] !== exp_pc[i]) begin
        miscompares++;
        $display("FAIL branch_pcf c%0d: got %h exp %h", i, pc_trace[i], exp_pc[i]);
      end
    end
    vectors++;
    if (got_st.size() != 1 || got_st[0] !== {32'h54, 32'd3}) begin
      miscompares++;
      $display("FAIL branch_flush_store: got n=%0d first=%h exp n=1 %h", got_st.size(),
               (got_st.size() > 0) ? got_st[0] : 64'hx, {32'h54, 32'd3});
    end
  endtask

  task automatic test_x0();
    new_prog();
    emit(OP_ADDI, 1, 0, 0, 3);
    emit(OP_ADD, 0, 1, 1, 0);
    emit(OP_ADD, 6, 0, 0, 0);
    emit(OP_SW, 0, 0, 6, 'h58);
    emit(OP_HALT, 0, 0, 0, 0);
    run_dut(16);
    vectors++;
    if (got_st.size() != 1 || got_st[0] !== {32'h58, 32'd0}) begin
      miscompares++;
      $display("FAIL x0_no_forward: got n=%0d first=%h exp n=1 %h", got_st.size(),
               (got_st.size() > 0) ? got_st[0] : 64'hx, {32'h58, 32'd0});
    end
  endtask

  task automatic test_store_forward();
    new_prog();
    emit(OP_ADDI, 2, 0, 0, 9);
    emit(OP_SW, 0, 0, 2, 4);
    emit(OP_HALT, 0, 0, 0, 0);
    run_dut(12);
    vectors++;
    if (got_st.size() != 1 || got_st[0] !== {32'h4, 32'd9}) begin
      miscompares++;
      $display("FAIL store_forward: got n=%0d first=%h exp n=1 %h", got_st.size(),
               (got_st.size() > 0) ? got_st[0] : 64'hx, {32'h4, 32'd9});
    end
  endtask

  task automatic test_random();
    int k, rd, rs1, rs2;
    for (int p = 0; p < 10; p++) begin
      new_prog();
      foreach (dmem_init[j]) dmem_init[j] = $urandom;
      for (int n = 0; n < 24; n++) begin
        k = $urandom_range(0, 9);
        rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
        case (k)
          0, 1: emit(OP_ADDI, rd, rs1, 0, int'($urandom_range(0, 4095)) - 2048);
          2: emit(OP_ADD, rd, rs1, rs2, 0);
          3: emit(OP_SUB, rd, rs1, rs2, 0);
          4: emit(OP_AND, rd, rs1, rs2, 0);
          5: emit(OP_OR,  rd, rs1, rs2, 0);
          6: emit(OP_SLT, rd, rs1, rs2, 0);
          7: emit(OP_LW,  rd, 0, 0, 4 * int'($urandom_range(0, 15)));
          8: emit(OP_SW,  0, 0, rs2, 4 * int'($urandom_range(0, 15)));
          default:
            if ($urandom_range(0, 1) == 1) emit(OP_BEQ, 0, rs1, rs2, 4 * int'($urandom_range(2, 3)));
            else                           emit(OP_JAL, rd, 0, 0, 4 * int'($urandom_range(2, 3)));
        endcase
      end
      for (int x = 1; x < 8; x++) emit(OP_SW, 0, 0, x, 'h80 + 4 * x);
      emit(OP_HALT, 0, 0, 0, 0);
      ref_run();
      run_dut(prog.size() * 4 + 20);
      vectors++;
      if (got_st.size() != exp_st.size()) begin
        miscompares++;
        $display("FAIL random%0d_store_count: got %0d exp %0d", p, got_st.size(), exp_st.size());
      end
      foreach (exp_st[i]) begin
        vectors++;
        if (i >= got_st.size() || got_st[i] !== exp_st[i]) begin
          miscompares++;
          $display("FAIL random%0d_store %0d: got %h exp %h", p, i,
                   (i < got_st.size()) ? got_st[i] : 64'hx, exp_st[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_x0();
    test_store_forward();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
